// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding (also used by the receiver),
// oversampling ratio and parity-sense constants.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int OVERSAMPLE = 16;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_START  = START,
    S_DATA   = DATA,
    S_PARITY = PARITY,
    S_STOP   = STOP
  } uart_state_t;

endpackage

// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, DBIT data bits LSB-first, optional parity,
// SB_TICK oversampling ticks of stop. Bit timing from an external 16x s_tick.
// Optional feature macro: UART_TX_PARITY_EN (parity bit after the data bits).
module uart_tx_parity #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PAR_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       busy,
  output logic       tx
);

  import uart_pkg::*;

  // Tick counter must reach both the bit length and the stop length.
  localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam logic [S_W-1:0] BIT_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [2:0]     N_LAST    = 3'(DBIT - 1);

  // Reject parameter sets the datapath cannot represent.
  if ((DBIT < 1) || (DBIT > 8) || (PAR_ODD < 0) || (PAR_ODD > 1) || (SB_TICK < 1)) begin : g_bad_cfg
    $error("uart_tx_parity: unsupported parameter set");
  end

  uart_state_t    state_r, state_s;
  logic [S_W-1:0] s_r, s_s;
  logic [2:0]     n_r, n_s;
  logic [7:0]     shift_r, shift_s;
  logic           tx_r, tx_s;
  logic           busy_r;
  logic           done_s;

`ifdef UART_TX_PARITY_EN
  logic par_r, par_s;

  // Parity over the active data bits only, inverted for odd sense.
  function automatic logic calc_parity(input logic [7:0] data);
    logic p;
    p = 1'(PAR_ODD);
    for (int i = 0; i < DBIT; i++) begin
      p = p ^ data[i];
    end
    return p;
  endfunction
`endif

  // Next-state, counter and next-line-value logic for the frame sequencer.
  always_comb begin
    state_s = state_r;
    s_s     = s_r;
    n_s     = n_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    done_s  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_s   = par_r;
`endif
    case (state_r)
      S_IDLE: begin
        tx_s = 1'b1;
        if (tx_start) begin
          state_s = S_START;
          s_s     = {S_W{1'b0}};
          shift_s = din;
`ifdef UART_TX_PARITY_EN
          par_s   = calc_parity(din);
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        tx_s = 1'b0;
        if (s_tick) begin
          if (s_r == BIT_LAST) begin
            state_s = S_DATA;
            s_s     = {S_W{1'b0}};
            n_s     = 3'd0;
          end else begin
            s_s = s_r + 1'b1;
          end
        end else begin
          s_s = s_r;
        end
      end
      S_DATA: begin
        tx_s = shift_r[0];
        if (s_tick) begin
          if (s_r == BIT_LAST) begin
            s_s     = {S_W{1'b0}};
            shift_s = {1'b0, shift_r[7:1]};
            if (n_r == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_s = S_PARITY;
`else
              state_s = S_STOP;
`endif
            end else begin
              n_s = n_r + 3'd1;
            end
          end else begin
            s_s = s_r + 1'b1;
          end
        end else begin
          s_s = s_r;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_s = par_r;
        if (s_tick) begin
          if (s_r == BIT_LAST) begin
            state_s = S_STOP;
            s_s     = {S_W{1'b0}};
          end else begin
            s_s = s_r + 1'b1;
          end
        end else begin
          s_s = s_r;
        end
      end
`endif
      S_STOP: begin
        tx_s = 1'b1;
        if (s_tick) begin
          if (s_r == STOP_LAST) begin
            state_s = S_IDLE;
            s_s     = {S_W{1'b0}};
            done_s  = 1'b1;
          end else begin
            s_s = s_r + 1'b1;
          end
        end else begin
          s_s = s_r;
        end
      end
      default: begin
        state_s = S_IDLE;
        s_s     = {S_W{1'b0}};
        n_s     = 3'd0;
        tx_s    = 1'b1;
      end
    endcase
  end

  // State, counters, shift register and registered line/busy outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      s_r     <= {S_W{1'b0}};
      n_r     <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      s_r     <= s_s;
      n_r     <= n_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != S_IDLE);
`ifdef UART_TX_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

  // The done pulse coincides with the final stop tick so busy drops next cycle.
  assign tx_done_tick = done_s;
  assign busy         = busy_r;
  assign tx           = tx_r;

endmodule
